// File: rtl/aes_req_sched.sv
// aes_req_sched: round-robin scheduler sharing one AES-128 core among NREQ requesters.
// Ports: clk, rst (async active-low); req_valid/req_ready/req_key/req_text (per-requester jobs);
//   rsp_valid/rsp_ready/rsp_id/rsp_data (shared response channel);
//   core_ld/core_key/core_text_in/core_done/core_text_out (cipher core); timeout_err (watchdog pulse).
module aes_req_sched #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 31
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*128-1:0]  req_key,
   input  logic [NREQ*128-1:0]  req_text,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [127:0]         rsp_data,
   output logic                 core_ld,
   output logic [127:0]         core_key,
   output logic [127:0]         core_text_in,
   input  logic                 core_done,
   input  logic [127:0]         core_text_out,
   output logic                 timeout_err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int LW = IDW + 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      BUSY,
      RESP
   } state_t;

   state_t           state;
   logic [IDW-1:0]   last_grant;
   logic [TW-1:0]    timer;

   logic             any_v;
   logic [IDW-1:0]   gnt;
   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]  rot;
   logic [LW-1:0]    base;
   logic [LW-1:0]    sum;
   logic [127:0]     key_sel;
   logic [127:0]     text_sel;

   // Rotate the valid vector so bit 0 is the requester just after
   // last_grant; the lowest set bit of the rotated view is the winner.
   always_comb begin
      any_v = |req_valid;
      dbl   = {req_valid, req_valid};
      base  = LW'(last_grant) + LW'(1);
      rot   = NREQ'(dbl >> base);
      sum   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum = base + LW'(i);
         end
      end
      if (sum >= LW'(NREQ)) begin
         sum = sum - LW'(NREQ);
      end
      gnt = sum[IDW-1:0];
   end

   always_comb begin
      key_sel  = '0;
      text_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt == IDW'(i)) begin
            key_sel  = req_key[i*128 +: 128];
            text_sel = req_text[i*128 +: 128];
         end
      end
   end

   // Gated by rst so the accept strobe is quiet while reset is held.
   always_comb begin
      req_ready = '0;
      if (rst && state == IDLE && any_v) begin
         req_ready[gnt] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         last_grant   <= IDW'(NREQ - 1);
         timer        <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_data     <= '0;
         core_ld      <= 1'b0;
         core_key     <= '0;
         core_text_in <= '0;
         timeout_err  <= 1'b0;
      end else begin
         core_ld     <= 1'b0;
         timeout_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_v) begin
                  core_key     <= key_sel;
                  core_text_in <= text_sel;
                  rsp_id       <= gnt;
                  last_grant   <= gnt;
                  core_ld      <= 1'b1;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               timer <= '0;
               state <= BUSY;
            end
            BUSY: begin
               timer <= timer + TW'(1);
               if (core_done) begin
                  rsp_data  <= core_text_out;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_req_sched.sv
// tb_aes_req_sched: randomized directed bench for aes_req_sched
// with a stub cipher core and a round-robin reference model.
module tb_aes_req_sched;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 31;

   localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*128-1:0] req_key = '0;
   logic [NREQ*128-1:0] req_text = '0;
   logic                rsp_valid;
   logic                rsp_ready = 1'b1;
   logic [IDW-1:0]      rsp_id;
   logic [127:0]        rsp_data;
   logic                core_ld;
   logic [127:0]        core_key;
   logic [127:0]        core_text_in;
   logic                core_done;
   logic [127:0]        core_text_out = '0;
   logic                timeout_err;

   logic                core_done_m = 1'b0;
   logic                stale_done = 1'b0;
   bit                  core_hang = 1'b0;
   int                  cd_cnt = 0;
   logic [127:0]        pend = '0;

   int checks = 0;
   int errors = 0;
   int lg = NREQ - 1;
   int mh_viol = 0;
   int to_cnt = 0;
   logic [127:0] kv [NREQ];
   logic [127:0] tv [NREQ];

   assign core_done = core_done_m | stale_done;

   aes_req_sched #(
      .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_key(req_key), .req_text(req_text),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data),
      .core_ld(core_ld), .core_key(core_key),
      .core_text_in(core_text_in), .core_done(core_done),
      .core_text_out(core_text_out), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Stub core: the FIPS-197 pair maps to its known ciphertext,
   // anything else to a cheap keyed mix. Done arrives 12 cycles after ld.
   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
      if (k == FK && t == FP) return FC;
      return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_3c3c_c3c3_9696_6969;
   endfunction

   always @(posedge clk) begin
      core_done_m <= 1'b0;
      if (cd_cnt > 0) begin
         cd_cnt <= cd_cnt - 1;
         if (cd_cnt == 1) begin
            core_done_m   <= 1'b1;
            core_text_out <= pend;
         end
      end
      if (core_ld && !core_hang) begin
         cd_cnt <= 11;
         pend   <= core_fn(core_key, core_text_in);
      end
   end

   always @(negedge clk) begin
      if (!$onehot0(req_ready)) mh_viol <= mh_viol + 1;
      if (timeout_err === 1'b1) to_cnt <= to_cnt + 1;
   end

   // Round-robin reference: first valid index after the last grant.
   function automatic int pick(input logic [NREQ-1:0] m);
      for (int k = 1; k <= NREQ; k++) begin
         int idx = (lg + k) % NREQ;
         if (m[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_data();
      for (int i = 0; i < NREQ; i++) begin
         req_key[i*128 +: 128]  = kv[i];
         req_text[i*128 +: 128] = tv[i];
      end
   endtask

   task automatic rand_data();
      for (int i = 0; i < NREQ; i++) begin
         kv[i] = {$urandom, $urandom, $urandom, $urandom};
         tv[i] = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   // Called in the cycle a grant is expected; returns in the cycle
   // after the response handshake, when the next grant may occur.
   task automatic run_job(input logic [NREQ-1:0] m, input int hold);
      int g;
      int bad;
      logic [127:0] ed;
      drive_data();
      req_valid = m;
      #1;
      g  = pick(m);
      ed = core_fn(kv[g], tv[g]);
      chk("grant", 128'(req_ready), 128'(1) << g);
      lg = g;
      tick();
      chk("core_ld", 128'(core_ld), 128'(1));
      chk("core_key", core_key, kv[g]);
      chk("core_text_in", core_text_in, tv[g]);
      bad = 0;
      if (req_ready != 0 || timeout_err !== 1'b0) bad++;
      for (int c = 2; c <= 13; c++) begin
         tick();
         if (core_ld !== 1'b0 || rsp_valid !== 1'b0) bad++;
         if (req_ready != 0 || timeout_err !== 1'b0) bad++;
         if (core_key !== kv[g]) bad++;
      end
      chk("busy_quiet", 128'(bad), 128'(0));
      tick();
      if (hold > 0) rsp_ready = 1'b0;
      chk("rsp_valid", 128'(rsp_valid), 128'(1));
      chk("rsp_id", 128'(rsp_id), 128'(g));
      chk("rsp_data", rsp_data, ed);
      if (hold > 0) begin
         bad = 0;
         for (int h = 1; h <= hold; h++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g)) bad++;
            if (rsp_data !== ed || req_ready != 0) bad++;
         end
         rsp_ready = 1'b1;
         chk("hold_stable", 128'(bad), 128'(0));
      end
      tick();
      chk("rsp_drop", 128'(rsp_valid), 128'(0));
   endtask

   initial begin
      logic [NREQ-1:0] m;
      int g;
      int bad;

      #2 rst = 1'b0;
      #1;
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_rsp_id", 128'(rsp_id), 128'(0));
      chk("rst_rsp_data", rsp_data, 128'(0));
      chk("rst_core_ld", 128'(core_ld), 128'(0));
      chk("rst_core_key", core_key, 128'(0));
      chk("rst_core_text", core_text_in, 128'(0));
      chk("rst_timeout", 128'(timeout_err), 128'(0));
      tick();
      tick();
      rst = 1'b1;
      tick();

      // FIPS-197 vector through requester 0
      rand_data();
      kv[0] = FK;
      tv[0] = FP;
      run_job(4'b0001, 0);

      // all requesters continuously valid
      for (int j = 0; j < 5; j++) begin
         rand_data();
         run_job(4'b1111, 0);
      end

      // requesters 1 and 3 only
      lg = 1;
      run_job(4'b0001 << 1, 0);
      run_job(4'b1010, 0);
      run_job(4'b1010, 0);

      // consumer stalls 20 cycles
      rand_data();
      run_job(4'($urandom_range(1, 15)), 20);

      // random traffic
      for (int j = 0; j < 6; j++) begin
         rand_data();
         run_job(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
      end

      // hung core: watchdog abort
      core_hang = 1'b1;
      m = 4'($urandom_range(1, 15));
      drive_data();
      req_valid = m;
      #1;
      g = pick(m);
      chk("to_grant", 128'(req_ready), 128'(1) << g);
      lg = g;
      tick();
      chk("to_core_ld", 128'(core_ld), 128'(1));
      bad = 0;
      for (int c = 2; c <= 32; c++) begin
         tick();
         if (timeout_err !== 1'b0 || rsp_valid !== 1'b0) bad++;
         if (req_ready != 0) bad++;
      end
      chk("to_wait", 128'(bad), 128'(0));
      tick();
      chk("to_pulse", 128'(timeout_err), 128'(1));
      chk("to_no_rsp", 128'(rsp_valid), 128'(0));
      core_hang = 1'b0;
      rand_data();
      run_job(4'b1111, 0);

      // reset in cycle 6 of a job, then a stale done
      rand_data();
      m = 4'b0100;
      drive_data();
      req_valid = m;
      #1;
      g = pick(m);
      chk("mr_grant", 128'(req_ready), 128'(1) << g);
      for (int c = 1; c <= 6; c++) tick();
      rst = 1'b0;
      #1;
      chk("mr_req_ready", 128'(req_ready), 128'(0));
      chk("mr_core_key", core_key, 128'(0));
      chk("mr_core_text", core_text_in, 128'(0));
      chk("mr_rsp_id", 128'(rsp_id), 128'(0));
      chk("mr_core_ld", 128'(core_ld), 128'(0));
      lg = NREQ - 1;
      req_valid = '0;
      tick();
      tick();
      rst = 1'b1;
      bad = 0;
      for (int c = 9; c <= 16; c++) begin
         tick();
         stale_done = (c == 10);
         if (rsp_valid !== 1'b0 || core_ld !== 1'b0) bad++;
         if (rsp_data !== 128'(0) || timeout_err !== 1'b0) bad++;
      end
      stale_done = 1'b0;
      chk("mr_stale_ignored", 128'(bad), 128'(0));
      rand_data();
      run_job(4'b1111, 0);

      chk("onehot_ready", 128'(mh_viol), 128'(0));
      chk("timeout_once", 128'(to_cnt), 128'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
